// File: rtl/codec_cfg_seq.sv
// Power-up configuration sequencer for a WM8731-class codec: walks a fixed
// register table through an external I2C write engine, then enables capture.
module codec_cfg_seq #(
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter int         PWR_WAIT     = 50000,
  parameter int         GAP_WAIT     = 500,
  parameter int         DONE_TIMEOUT = 100000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_wr_req,
  output logic [6:0]  o_wr_dev,
  output logic [15:0] o_wr_data,
  input  logic        i_wr_ack,
  input  logic        i_wr_done,
  input  logic        i_wr_err,
  output logic        o_cfg_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  output logic        o_rx_en,
  output logic [3:0]  o_reg_idx
);
  localparam int CNT_A   = (PWR_WAIT > DONE_TIMEOUT) ? PWR_WAIT : DONE_TIMEOUT;
  localparam int CNT_MAX = (CNT_A > GAP_WAIT) ? CNT_A : GAP_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {S_PWR, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0]    idx_q, idx_d;
  logic          req_q, busy_q, done_q, err_q;
  logic [15:0]   data_q;
  logic          fin, fail;

  function automatic logic [15:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = 16'h1E00;
      4'd1:    tbl = 16'h0017;
      4'd2:    tbl = 16'h0217;
      4'd3:    tbl = 16'h0812;
      4'd4:    tbl = 16'h0A00;
      4'd5:    tbl = 16'h0C00;
      4'd6:    tbl = 16'h0E42;
      4'd7:    tbl = 16'h1000;
      4'd8:    tbl = 16'h1201;
      default: tbl = 16'h0000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    fin     = 1'b0;
    fail    = 1'b0;
    case (state_q)
      S_PWR:
        if (cnt_q == CW'(PWR_WAIT - 1)) begin state_d = S_ISSUE; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      S_ISSUE:
        if (i_wr_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          // a done arriving together with the ack resolves the write right away
          if (i_wr_done) begin fin = 1'b1; fail = i_wr_err; end
        end
      S_WAIT:
        if (i_wr_done) begin fin = 1'b1; fail = i_wr_err; end
        else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin fin = 1'b1; fail = 1'b1; end
        else cnt_d = cnt_q + 1'b1;
      S_GAP:
        if (cnt_q == CW'(GAP_WAIT - 1)) begin state_d = S_ISSUE; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      S_DONE, S_ERR:
        if (i_start) begin
          state_d = S_PWR;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
        end
      default: state_d = S_PWR;
    endcase
    if (fin) begin
      cnt_d = '0;
      if (!fail) begin
        retry_d = '0;
        if (idx_q == 4'd8) state_d = S_DONE;
        else begin idx_d = idx_q + 4'd1; state_d = S_GAP; end
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = (retry_d == RW'(MAX_RETRY)) ? S_ERR : S_GAP;
      end
    end
  end

  // outputs are registered from next state so they line up with state_q
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q <= S_PWR;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      req_q   <= (state_d == S_ISSUE);
      busy_q  <= !(state_d == S_DONE || state_d == S_ERR);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
      data_q  <= tbl(idx_d);
    end
  end

  assign o_wr_req   = req_q;
  assign o_wr_dev   = DEV_ADDR;
  assign o_wr_data  = data_q;
  assign o_cfg_busy = busy_q;
  assign o_cfg_done = done_q;
  assign o_cfg_err  = err_q;
  assign o_rx_en    = done_q;
  assign o_reg_idx  = idx_q;
endmodule
